dm_arbiter: RTL and testbench
=============================

# dm_arbiter

Two-requester arbiter for the single byte-enabled data-memory port. It shares the port between the CPU MEM stage (primary) and a secondary master, such as a debug or DMA bridge. The CPU has priority, subject to a starvation limit for the secondary and optional locked secondary bursts. The block sits between the MEM-stage store-lane steering logic and the DM interface (m_data_*).

## Interface
Parameters:
- STARVE_LIMIT, 4, consecutive cycles the secondary may wait while the CPU holds the port; range 1..15.
- BURST_MAX, 4, maximum beats of one locked secondary burst; range 1..15.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  MEM stage has a load or store this cycle.
- cpu_we  in  1  CPU access is a store.
- cpu_addr  in  32  CPU byte address.
- cpu_wdata  in  32  CPU store data, already lane-aligned.
- cpu_byteen  in  4  CPU lane enables, already computed.
- cpu_stall  out  1  CPU must hold the MEM stage.
- cpu_rdata  out  32  load data; equals m_data_rdata.
- sec_valid  in  1  secondary request.
- sec_lock  in  1  keep ownership after this beat.
- sec_we  in  1  secondary store.
- sec_addr  in  32  secondary byte address.
- sec_wdata  in  32  secondary store data.
- sec_byteen  in  4  secondary lane enables.
- sec_ready  out  1  secondary beat accepted this cycle.
- sec_rvalid  out  1  secondary read data valid, registered.
- sec_rdata  out  32  secondary read data, registered.
- m_data_addr  out  32  DM address.
- m_data_wdata  out  32  DM write data.
- m_data_byteen  out  4  DM write enables.
- m_data_rdata  in  32  DM combinational read data.

## Operation
FSM states: OWN_CPU (reset state) and OWN_SEC.

Grant in OWN_CPU:
- grant_sec = sec_valid && (!cpu_req || starve == STARVE_LIMIT).
- Otherwise the CPU owns the port when cpu_req is high.

Grant in OWN_SEC:
- grant_sec = sec_valid.
- cpu_stall = cpu_req.

Other grant rules:
- cpu_stall = cpu_req && !grant_cpu.
- sec_ready = grant_sec.

Port mux (combinational):
- Owner's addr and wdata drive the DM port.
- m_data_byteen = owner_we ? owner_byteen : 4'b0000.
- With no owner: addr, wdata and byteen are all 0.

Starvation counter (saturating at STARVE_LIMIT):
- Increments when sec_valid && cpu_req && grant_cpu.
- Clears when grant_sec is high or sec_valid is low.

Transitions:
- OWN_CPU→OWN_SEC when grant_sec && sec_lock. The beat counter is then set to 1.
- OWN_SEC increments the beat counter on each accepted beat.
- OWN_SEC→OWN_CPU after an accepted beat with sec_lock=0, or when sec_valid=0, or when the beat counter reaches BURST_MAX.
- A forced exit at BURST_MAX guarantees the CPU one grant cycle before the next grant_sec, whenever cpu_req is high.

Read return:
- On an accepted secondary read (grant_sec && !sec_we), sec_rdata <= m_data_rdata and sec_rvalid pulses high for exactly one cycle.
- Back-to-back reads produce back-to-back pulses.

No realignment or checking is done here. Lane steering and address checks are upstream.

## Timing
- Grant and port mux are zero latency: a request is presented to the DM in the same cycle.
- Writes commit at the next clk edge.
- cpu_rdata is valid in the same cycle when cpu_stall=0.
- Secondary read latency is 1 cycle: sec_rvalid appears the cycle after sec_ready.
- Reset values: state OWN_CPU, starve 0, beat 0, sec_rvalid 0, sec_rdata 0. With all inputs low, every combinational output is 0.
- Reset mid-burst immediately returns the FSM to OWN_CPU and drops any pending sec_rvalid. m_data_byteen is 0 while reset is high.
- Simultaneous cpu_req and sec_valid at starve == STARVE_LIMIT: the secondary wins, and starve clears at the same edge.

## Configuration
- DM_ARB_STARVE_EN defined: starvation counter and forced secondary grant as above.
- DM_ARB_STARVE_EN undefined: strict CPU priority.
  - grant_sec in OWN_CPU = sec_valid && !cpu_req.
  - Starvation counter is not built.
  - Locked bursts still honour BURST_MAX.

## Structure
- Shared definitions header def.v holds:
  - FSM state encodings DMARB_OWN_CPU=1'b0 and DMARB_OWN_SEC=1'b1.
  - Default values for STARVE_LIMIT and BURST_MAX.
- One natural sub-module: dm_arb_starve, the saturating starvation counter with its clear/increment logic. It is instantiated only under DM_ARB_STARVE_EN.

## Test plan
All scenarios use STARVE_LIMIT=4 and BURST_MAX=4.
- Reset: assert reset with random inputs → m_data_byteen=0, sec_rvalid=0, state OWN_CPU, cpu_stall=0.
- CPU store alone: cpu_req=1, we=1, addr=0x104, byteen=4'b0100, wdata=0x00AB0000 → same-cycle m_data_* mirror, sec_ready=0, cpu_stall=0.
- Starvation: cpu_req=1 and sec_valid=1 held from cycle 0 → sec_ready=0 for cycles 0–3. Cycle 4: sec_ready=1 and cpu_stall=1. Cycle 5: CPU owns the port again.
- Secondary read with CPU idle: sec_addr=0x200, DM word=0x12345678 → sec_ready=1 at cycle 0; cycle 1: sec_rvalid=1 and sec_rdata=0x12345678; cycle 2: sec_rvalid=0.
- Locked burst: sec_lock=1 for 6 beats with cpu_req=1 → 4 consecutive beats with cpu_stall=1, then one CPU cycle with sec_ready=0, then the burst resumes.
- Reset mid-burst: reset pulsed at beat 2 → OWN_CPU, sec_rvalid=0, m_data_byteen=0 in the same cycle.

Source files
------------

// File: rtl/dm_arbiter_pkg.sv
// rtl/dm_arbiter_pkg.sv - ownership encodings and parameter defaults for the data-memory arbiter
package dm_arbiter_pkg;

  typedef enum logic {
    DMARB_OWN_CPU = 1'b0,
    DMARB_OWN_SEC = 1'b1
  } dmarb_state_e;

  localparam int unsigned DMARB_STARVE_LIMIT_DEF = 4;
  localparam int unsigned DMARB_BURST_MAX_DEF    = 4;
  localparam int unsigned DMARB_CNT_W            = 4;

endpackage

// File: rtl/dm_arb_starve.sv
// rtl/dm_arb_starve.sv - saturating count of cycles the secondary has waited behind the CPU
module dm_arb_starve
  import dm_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = DMARB_STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam logic [DMARB_CNT_W-1:0] LIMIT = DMARB_CNT_W'(STARVE_LIMIT);
  localparam logic [DMARB_CNT_W-1:0] ONE   = DMARB_CNT_W'(1);

  logic [DMARB_CNT_W-1:0] starve_q, starve_d;

  always_comb begin
    starve_d = starve_q;
    if (clr) begin
      starve_d = '0;
    end else if (inc && (starve_q != LIMIT)) begin
      starve_d = starve_q + ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  assign at_limit = (starve_q == LIMIT);

endmodule

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - CPU/secondary arbiter for the data-memory port
// Optional starvation-forced secondary grant is built when DM_ARB_STARVE_EN is defined.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = DMARB_STARVE_LIMIT_DEF,
  parameter int unsigned BURST_MAX    = DMARB_BURST_MAX_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_byteen,
  output logic        cpu_stall,
  output logic [31:0] cpu_rdata,
  input  logic        sec_valid,
  input  logic        sec_lock,
  input  logic        sec_we,
  input  logic [31:0] sec_addr,
  input  logic [31:0] sec_wdata,
  input  logic [3:0]  sec_byteen,
  output logic        sec_ready,
  output logic        sec_rvalid,
  output logic [31:0] sec_rdata,
  output logic [31:0] m_data_addr,
  output logic [31:0] m_data_wdata,
  output logic [3:0]  m_data_byteen,
  input  logic [31:0] m_data_rdata
);

  localparam logic [DMARB_CNT_W-1:0] BMAX = DMARB_CNT_W'(BURST_MAX);
  localparam logic [DMARB_CNT_W-1:0] ONE  = DMARB_CNT_W'(1);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15 || BURST_MAX < 1 || BURST_MAX > 15) begin : g_param_check
    $error("dm_arbiter: STARVE_LIMIT and BURST_MAX must lie in 1..15");
  end

  dmarb_state_e           state_q, state_d;
  logic [DMARB_CNT_W-1:0] beat_q, beat_d;
  logic [DMARB_CNT_W-1:0] beat_inc;
  logic                   sec_rvalid_q, sec_rvalid_d;
  logic [31:0]            sec_rdata_q, sec_rdata_d;
  logic                   grant_sec, grant_cpu;
  logic                   starve_hit;

`ifdef DM_ARB_STARVE_EN
  logic starve_inc, starve_clr;

  assign starve_inc = sec_valid && cpu_req && grant_cpu;
  assign starve_clr = grant_sec || !sec_valid;

  dm_arb_starve #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .reset    (reset),
    .inc      (starve_inc),
    .clr      (starve_clr),
    .at_limit (starve_hit)
  );
`else
  assign starve_hit = 1'b0;
`endif

  assign beat_inc = beat_q + ONE;

  always_comb begin
    grant_sec = 1'b0;
    grant_cpu = 1'b0;
    state_d   = state_q;
    beat_d    = beat_q;
    case (state_q)
      DMARB_OWN_CPU: begin
        grant_sec = sec_valid && (!cpu_req || starve_hit);
        grant_cpu = cpu_req && !grant_sec;
        // A one-beat burst limit means a locked beat never needs to hold the port.
        if (grant_sec && sec_lock && (BURST_MAX > 1)) begin
          state_d = DMARB_OWN_SEC;
          beat_d  = ONE;
        end
      end
      DMARB_OWN_SEC: begin
        grant_sec = sec_valid;
        if (!sec_valid || !sec_lock || (beat_inc == BMAX)) begin
          state_d = DMARB_OWN_CPU;
          beat_d  = '0;
        end else begin
          beat_d = beat_inc;
        end
      end
      default: begin
        state_d = DMARB_OWN_CPU;
        beat_d  = '0;
      end
    endcase
  end

  always_comb begin
    m_data_addr   = '0;
    m_data_wdata  = '0;
    m_data_byteen = '0;
    if (grant_sec) begin
      m_data_addr  = sec_addr;
      m_data_wdata = sec_wdata;
      if (sec_we) m_data_byteen = sec_byteen;
    end else if (grant_cpu) begin
      m_data_addr  = cpu_addr;
      m_data_wdata = cpu_wdata;
      if (cpu_we) m_data_byteen = cpu_byteen;
    end
    // No write may reach the memory while the arbiter is held in reset.
    if (reset) m_data_byteen = '0;
  end

  always_comb begin
    sec_rvalid_d = grant_sec && !sec_we;
    sec_rdata_d  = sec_rvalid_d ? m_data_rdata : sec_rdata_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= DMARB_OWN_CPU;
      beat_q       <= '0;
      sec_rvalid_q <= 1'b0;
      sec_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      sec_rvalid_q <= sec_rvalid_d;
      sec_rdata_q  <= sec_rdata_d;
    end
  end

  assign cpu_stall  = cpu_req && !grant_cpu;
  assign cpu_rdata  = m_data_rdata;
  assign sec_ready  = grant_sec;
  assign sec_rvalid = sec_rvalid_q;
  assign sec_rdata  = sec_rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - directed bench for dm_arbiter with a cycle-level ownership model
module tb_dm_arbiter;

  localparam int SL = 4;
  localparam int BM = 4;
`ifdef DM_ARB_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [3:0]  cpu_byteen;
  logic        cpu_stall;
  logic [31:0] cpu_rdata;
  logic        sec_valid, sec_lock, sec_we;
  logic [31:0] sec_addr, sec_wdata;
  logic [3:0]  sec_byteen;
  logic        sec_ready, sec_rvalid;
  logic [31:0] sec_rdata;
  logic [31:0] m_data_addr, m_data_wdata, m_data_rdata;
  logic [3:0]  m_data_byteen;

  dm_arbiter #(.STARVE_LIMIT(SL), .BURST_MAX(BM)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_byteen(cpu_byteen), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
    .sec_valid(sec_valid), .sec_lock(sec_lock), .sec_we(sec_we), .sec_addr(sec_addr),
    .sec_wdata(sec_wdata), .sec_byteen(sec_byteen), .sec_ready(sec_ready),
    .sec_rvalid(sec_rvalid), .sec_rdata(sec_rdata),
    .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata),
    .m_data_byteen(m_data_byteen), .m_data_rdata(m_data_rdata)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: who holds the port, how long the secondary has waited, burst beats done.
  bit          m_holds = 1'b0;
  int          m_beats = 0;
  int          m_waited = 0;
  bit          m_rv = 1'b0;
  logic [31:0] m_rd = '0;
  bit          e_sw, e_cg;
  logic [31:0] e_addr, e_wdata;
  logic [3:0]  e_be;

  always @(negedge clk) begin
    if (reset) begin
      m_holds = 1'b0; m_beats = 0; m_waited = 0; m_rv = 1'b0; m_rd = '0;
    end
    if (m_holds) e_sw = sec_valid;
    else         e_sw = sec_valid && (!cpu_req || (STARVE_ON && m_waited >= SL));
    e_cg    = !m_holds && cpu_req && !e_sw;
    e_addr  = e_sw ? sec_addr  : (e_cg ? cpu_addr  : 32'h0);
    e_wdata = e_sw ? sec_wdata : (e_cg ? cpu_wdata : 32'h0);
    e_be    = 4'h0;
    if (!reset) begin
      if (e_sw && sec_we)      e_be = sec_byteen;
      else if (e_cg && cpu_we) e_be = cpu_byteen;
    end
    chk("sec_ready", sec_ready, e_sw);
    chk("cpu_stall", cpu_stall, cpu_req && !e_cg);
    chk("m_data_addr", m_data_addr, e_addr);
    chk("m_data_wdata", m_data_wdata, e_wdata);
    chk("m_data_byteen", m_data_byteen, e_be);
    chk("cpu_rdata", cpu_rdata, m_data_rdata);
    chk("sec_rvalid", sec_rvalid, m_rv);
    chk("sec_rdata", sec_rdata, m_rd);
    chk("state", dut.state_q, m_holds);
    if (!reset) begin
      if (!sec_valid || e_sw) m_waited = 0;
      else if (e_cg && m_waited < SL) m_waited++;
      if (m_holds) begin
        if (!sec_valid) m_holds = 1'b0;
        else begin
          m_beats++;
          if (!sec_lock || m_beats >= BM) m_holds = 1'b0;
        end
      end else if (e_sw && sec_lock && BM > 1) begin
        m_holds = 1'b1;
        m_beats = 1;
      end
      m_rv = e_sw && !sec_we;
      if (m_rv) m_rd = m_data_rdata;
    end
  end

  task automatic zero_all();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; cpu_byteen = '0;
    sec_valid = 0; sec_lock = 0; sec_we = 0; sec_addr = '0; sec_wdata = '0; sec_byteen = '0;
    m_data_rdata = '0;
  endtask

  task automatic set_defaults();
    cpu_addr = 32'h1000_0010; cpu_wdata = 32'hC0C0_C0C0; cpu_byteen = 4'b0011;
    sec_addr = 32'h2000_0020; sec_wdata = 32'h5E5E_5E5E; sec_byteen = 4'b1100;
  endtask

  task automatic cyc(input bit cq, input bit cw, input bit sv, input bit sl, input bit sw,
                     input logic [31:0] rd);
    @(posedge clk); #1;
    cpu_req = cq; cpu_we = cw; sec_valid = sv; sec_lock = sl; sec_we = sw; m_data_rdata = rd;
  endtask

  logic [7:0] v_cq, v_sv, v_lk, v_rdy, v_stl, v_st;
  logic [3:0] v_be [8];

  initial begin
    reset = 1'b1;
    zero_all();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      {cpu_req, cpu_we, sec_valid, sec_lock, sec_we} = 5'($urandom);
      cpu_addr = $urandom; cpu_wdata = $urandom; cpu_byteen = 4'($urandom);
      sec_addr = $urandom; sec_wdata = $urandom; sec_byteen = 4'($urandom);
      m_data_rdata = $urandom;
      #2;
      chk("lit_rst_byteen", m_data_byteen, 32'h0);
      chk("lit_rst_rvalid", sec_rvalid, 32'h0);
      chk("lit_rst_stall", cpu_stall, 32'h0);
      chk("lit_rst_state", dut.state_q, 32'h0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    zero_all();
    #2;
    chk("lit_idle_stall", cpu_stall, 32'h0);
    chk("lit_idle_ready", sec_ready, 32'h0);
    chk("lit_idle_addr", m_data_addr, 32'h0);
    chk("lit_idle_wdata", m_data_wdata, 32'h0);
    chk("lit_idle_byteen", m_data_byteen, 32'h0);
    chk("lit_idle_rdata", sec_rdata, 32'h0);

    cyc(1, 1, 0, 0, 0, 32'h0);
    cpu_addr = 32'h104; cpu_byteen = 4'b0100; cpu_wdata = 32'h00AB_0000;
    #2;
    chk("lit_st_addr", m_data_addr, 32'h104);
    chk("lit_st_wdata", m_data_wdata, 32'h00AB_0000);
    chk("lit_st_byteen", m_data_byteen, 32'h4);
    chk("lit_st_ready", sec_ready, 32'h0);
    chk("lit_st_stall", cpu_stall, 32'h0);

    cyc(1, 0, 0, 0, 0, 32'hCAFE_F00D);
    #2;
    chk("lit_ld_rdata", cpu_rdata, 32'hCAFE_F00D);
    chk("lit_ld_byteen", m_data_byteen, 32'h0);

    set_defaults();
    cyc(0, 0, 1, 0, 0, 32'h1234_5678);
    sec_addr = 32'h200;
    #2;
    chk("lit_rd_ready", sec_ready, 32'h1);
    chk("lit_rd_addr", m_data_addr, 32'h200);
    cyc(0, 0, 0, 0, 0, 32'hDEAD_0000);
    #2;
    chk("lit_rd_rvalid1", sec_rvalid, 32'h1);
    chk("lit_rd_rdata1", sec_rdata, 32'h1234_5678);
    cyc(0, 0, 0, 0, 0, 32'h0);
    #2;
    chk("lit_rd_rvalid2", sec_rvalid, 32'h0);

    cyc(0, 0, 1, 0, 0, 32'h1111_1111);
    cyc(0, 0, 1, 0, 0, 32'h2222_2222);
    #2;
    chk("lit_b2b_v0", sec_rvalid, 32'h1);
    chk("lit_b2b_d0", sec_rdata, 32'h1111_1111);
    cyc(0, 0, 0, 0, 0, 32'h0);
    #2;
    chk("lit_b2b_v1", sec_rvalid, 32'h1);
    chk("lit_b2b_d1", sec_rdata, 32'h2222_2222);
    cyc(0, 0, 0, 0, 0, 32'h0);
    #2;
    chk("lit_b2b_v2", sec_rvalid, 32'h0);

    set_defaults();
    for (int i = 0; i < 7; i++) begin
      cyc(1, i[0], 1, 0, 1, 32'h0);
      #2;
      chk($sformatf("lit_starve_ready%0d", i), sec_ready, 32'(STARVE_ON && i == 4));
      chk($sformatf("lit_starve_stall%0d", i), cpu_stall, 32'(STARVE_ON && i == 4));
    end
    cyc(0, 0, 0, 0, 0, 32'h0);

    v_cq  = 8'b0001_1110;
    v_sv  = 8'b0111_1111;
    v_lk  = 8'b0111_1111;
    v_rdy = 8'b0110_1111;
    v_stl = 8'b0000_1110;
    v_st  = 8'b1100_1110;
    v_be  = '{4'hC, 4'hC, 4'hC, 4'hC, 4'h3, 4'hC, 4'hC, 4'h0};
    for (int i = 0; i < 8; i++) begin
      cyc(v_cq[i], 1, v_sv[i], v_lk[i], 1, 32'h0);
      #2;
      chk($sformatf("lit_burst_ready%0d", i), sec_ready, 32'(v_rdy[i]));
      chk($sformatf("lit_burst_stall%0d", i), cpu_stall, 32'(v_stl[i]));
      chk($sformatf("lit_burst_state%0d", i), dut.state_q, 32'(v_st[i]));
      chk($sformatf("lit_burst_be%0d", i), m_data_byteen, 32'(v_be[i]));
    end
    cyc(0, 0, 0, 0, 0, 32'h0);
    #2;
    chk("lit_burst_done", dut.state_q, 32'h0);

    cyc(0, 0, 1, 1, 0, 32'hA5A5_A5A5);
    @(posedge clk); #1;
    reset = 1'b1; sec_we = 1'b1;
    #2;
    chk("lit_mid_state", dut.state_q, 32'h0);
    chk("lit_mid_rvalid", sec_rvalid, 32'h0);
    chk("lit_mid_byteen", m_data_byteen, 32'h0);
    chk("lit_mid_rdata", sec_rdata, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    zero_all();
    #2;
    chk("lit_post_state", dut.state_q, 32'h0);
    chk("lit_post_rvalid", sec_rvalid, 32'h0);
    cyc(0, 0, 0, 0, 0, 32'h0);
    @(negedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
